// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle of request and broadcast signals around the common data bus arbiter.
//   master : requester / consumer side (drives REQ_*, observes GNT and CDB_*)
//   slave  : arbiter side (observes REQ_*, drives GNT and CDB_*)
// Signals
//   REQ_VALID [3:0]        per-unit request (0 LOAD_1, 1 LOAD_2, 2 ALU_1, 3 ALU_2)
//   REQ_TAG0..3 [TAG_W]    tag of each requester, tag 0 is invalid
//   REQ_DATA0..3 [DATA_W]  result data of each requester
//   GNT [3:0]              combinational one-hot grant
//   CDB_VALID/TAG/DATA/SRC registered broadcast
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32
);
   logic [3:0]        REQ_VALID;
   logic [TAG_W-1:0]  REQ_TAG0;
   logic [TAG_W-1:0]  REQ_TAG1;
   logic [TAG_W-1:0]  REQ_TAG2;
   logic [TAG_W-1:0]  REQ_TAG3;
   logic [DATA_W-1:0] REQ_DATA0;
   logic [DATA_W-1:0] REQ_DATA1;
   logic [DATA_W-1:0] REQ_DATA2;
   logic [DATA_W-1:0] REQ_DATA3;
   logic [3:0]        GNT;
   logic              CDB_VALID;
   logic [TAG_W-1:0]  CDB_TAG;
   logic [DATA_W-1:0] CDB_DATA;
   logic [1:0]        CDB_SRC;

   modport master (
      output REQ_VALID, REQ_TAG0, REQ_TAG1, REQ_TAG2, REQ_TAG3,
      output REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3,
      input  GNT, CDB_VALID, CDB_TAG, CDB_DATA, CDB_SRC
   );

   modport slave (
      input  REQ_VALID, REQ_TAG0, REQ_TAG1, REQ_TAG2, REQ_TAG3,
      input  REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3,
      output GNT, CDB_VALID, CDB_TAG, CDB_DATA, CDB_SRC
   );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for four result producers sharing one common data bus.
// A grant is issued combinationally in the request cycle; the winner's tag,
// data and index are broadcast from registers one cycle later.
// Ports
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   FLUSH  synchronous squash: no grant this cycle, pointer returns to 0
//   bus    cdb_arbiter_if.slave (requests in, grant and broadcast out)
// Optional feature (macro CDB_ARB_PERF_EN)
//   CDB_BUSY_CNT     [31:0] cycles with a grant
//   CDB_CONFLICT_CNT [31:0] cycles with two or more eligible requesters
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FLUSH,
`ifdef CDB_ARB_PERF_EN
   output logic [31:0] CDB_BUSY_CNT,
   output logic [31:0] CDB_CONFLICT_CNT,
`endif
   cdb_arbiter_if.slave bus
);

   logic [TAG_W-1:0]  tag_s  [4];
   logic [DATA_W-1:0] data_s [4];
   logic [3:0]        elig_s;
   logic              grant_any_s;
   logic [1:0]        grant_idx_s;
   logic [3:0]        gnt_s;

   logic [1:0]        ptr_r;
   logic              cdb_valid_r;
   logic [TAG_W-1:0]  cdb_tag_r;
   logic [DATA_W-1:0] cdb_data_r;
   logic [1:0]        cdb_src_r;

   // Round-robin pick: {hit, index} of the first eligible unit at or after ptr.
   function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
      logic       hit;
      logic [1:0] idx;
      logic [1:0] cand;
      hit  = 1'b0;
      idx  = 2'd0;
      cand = ptr;
      for (int off = 0; off < 4; off++) begin
         if (elig[cand] && !hit) begin
            hit = 1'b1;
            idx = cand;
         end else begin
            hit = hit;
         end
         cand = cand + 2'd1;
      end
      return {hit, idx};
   endfunction

   assign tag_s[0]  = bus.REQ_TAG0;
   assign tag_s[1]  = bus.REQ_TAG1;
   assign tag_s[2]  = bus.REQ_TAG2;
   assign tag_s[3]  = bus.REQ_TAG3;
   assign data_s[0] = bus.REQ_DATA0;
   assign data_s[1] = bus.REQ_DATA1;
   assign data_s[2] = bus.REQ_DATA2;
   assign data_s[3] = bus.REQ_DATA3;

   // Eligibility: a request carrying the invalid tag 0 is ignored.
   always_comb begin
      elig_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         elig_s[i] = bus.REQ_VALID[i] && (tag_s[i] != {TAG_W{1'b0}});
      end
   end

   // Grant selection; grant is held off during reset and flush.
   always_comb begin
      logic [2:0] pick;
      pick        = rr_pick(elig_s, ptr_r);
      grant_any_s = 1'b0;
      grant_idx_s = 2'd0;
      gnt_s       = 4'b0000;
      if (RST_N && !FLUSH && pick[2]) begin
         grant_any_s = 1'b1;
         grant_idx_s = pick[1:0];
         gnt_s       = 4'b0001 << pick[1:0];
      end else begin
         grant_any_s = 1'b0;
      end
   end

   // Pointer and broadcast registers; fields hold when nothing is granted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_r       <= 2'd0;
         cdb_valid_r <= 1'b0;
         cdb_tag_r   <= {TAG_W{1'b0}};
         cdb_data_r  <= {DATA_W{1'b0}};
         cdb_src_r   <= 2'd0;
      end else if (FLUSH) begin
         ptr_r       <= 2'd0;
         cdb_valid_r <= 1'b0;
      end else if (grant_any_s) begin
         ptr_r       <= grant_idx_s + 2'd1;
         cdb_valid_r <= 1'b1;
         cdb_tag_r   <= tag_s[grant_idx_s];
         cdb_data_r  <= data_s[grant_idx_s];
         cdb_src_r   <= grant_idx_s;
      end else begin
         cdb_valid_r <= 1'b0;
      end
   end

   assign bus.GNT       = gnt_s;
   assign bus.CDB_VALID = cdb_valid_r;
   assign bus.CDB_TAG   = cdb_tag_r;
   assign bus.CDB_DATA  = cdb_data_r;
   assign bus.CDB_SRC   = cdb_src_r;

`ifdef CDB_ARB_PERF_EN
   logic [2:0]  elig_cnt_s;
   logic [31:0] busy_cnt_r;
   logic [31:0] conflict_cnt_r;

   // Number of eligible requesters this cycle (flush does not mask it).
   always_comb begin
      elig_cnt_s = 3'd0;
      for (int i = 0; i < 4; i++) begin
         elig_cnt_s = elig_cnt_s + {2'b00, elig_s[i]};
      end
   end

   // Free-running wrap-around counters; only reset clears them.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         busy_cnt_r     <= 32'd0;
         conflict_cnt_r <= 32'd0;
      end else begin
         if (grant_any_s) begin
            busy_cnt_r <= busy_cnt_r + 32'd1;
         end else begin
            busy_cnt_r <= busy_cnt_r;
         end
         if (elig_cnt_s >= 3'd2) begin
            conflict_cnt_r <= conflict_cnt_r + 32'd1;
         end else begin
            conflict_cnt_r <= conflict_cnt_r;
         end
      end
   end

   assign CDB_BUSY_CNT     = busy_cnt_r;
   assign CDB_CONFLICT_CNT = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Scoreboard bench: the driver computes expected grants and broadcasts from a
// reference model of the arbitration rules and queues each expected broadcast;
// a monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
   localparam int TAG_W  = 4;
   localparam int DATA_W = 32;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic FLUSH = 1'b0;

   cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

`ifdef CDB_ARB_PERF_EN
   logic [31:0] busy_cnt;
   logic [31:0] conf_cnt;
`endif

   cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .FLUSH(FLUSH),
`ifdef CDB_ARB_PERF_EN
      .CDB_BUSY_CNT(busy_cnt),
      .CDB_CONFLICT_CNT(conf_cnt),
`endif
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic [1:0]        src;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // reference model state
   int                m_ptr;
   logic [TAG_W-1:0]  m_tag;
   logic [DATA_W-1:0] m_data;
   logic [1:0]        m_src;
   logic [31:0]       m_busy;
   logic [31:0]       m_conf;

   logic [TAG_W-1:0]  cur_tag  [4];
   logic [DATA_W-1:0] cur_data [4];
   logic              pend     [4];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One request cycle, entered at a falling edge and returning at the next one.
   task automatic cycle(input logic [3:0] v, input logic fl, output int g);
      logic [3:0] el;
      logic [3:0] one;
      logic [3:0] exp_gnt;
      int         n_el;
      int         k;
      exp_t       e;
      bus.REQ_VALID = v;
      bus.REQ_TAG0  = cur_tag[0];
      bus.REQ_TAG1  = cur_tag[1];
      bus.REQ_TAG2  = cur_tag[2];
      bus.REQ_TAG3  = cur_tag[3];
      bus.REQ_DATA0 = cur_data[0];
      bus.REQ_DATA1 = cur_data[1];
      bus.REQ_DATA2 = cur_data[2];
      bus.REQ_DATA3 = cur_data[3];
      FLUSH         = fl;
      #1;
      n_el = 0;
      for (int i = 0; i < 4; i++) begin
         el[i] = v[i] && (cur_tag[i] != 4'd0);
         if (el[i]) n_el++;
      end
      g = -1;
      if (!fl) begin
         for (int off = 0; off < 4; off++) begin
            k = (m_ptr + off) % 4;
            if (g < 0 && el[k]) g = k;
         end
      end
      one     = 4'b0001;
      exp_gnt = (g >= 0) ? (one << g) : 4'b0000;
      check("gnt", {60'd0, bus.GNT}, {60'd0, exp_gnt});
      if (fl) begin
         m_ptr = 0;
         e.valid = 1'b0;
      end else if (g >= 0) begin
         m_ptr  = (g + 1) % 4;
         m_tag  = cur_tag[g];
         m_data = cur_data[g];
         m_src  = 2'(g);
         e.valid = 1'b1;
         m_busy = m_busy + 32'd1;
      end else begin
         e.valid = 1'b0;
      end
      if (n_el >= 2) m_conf = m_conf + 32'd1;
      e.tag  = m_tag;
      e.data = m_data;
      e.src  = m_src;
      exp_q.push_back(e);
      @(negedge CLK);
   endtask

   // Asynchronous reset pulse asserted mid-cycle, released on a falling edge.
   task automatic do_reset();
      RST_N = 1'b0;
      #1;
      check("rst_valid", {63'd0, bus.CDB_VALID}, 64'd0);
      check("rst_tag",   {60'd0, bus.CDB_TAG},   64'd0);
      check("rst_data",  {32'd0, bus.CDB_DATA},  64'd0);
      check("rst_src",   {62'd0, bus.CDB_SRC},   64'd0);
      check("rst_gnt",   {60'd0, bus.GNT},       64'd0);
      m_ptr  = 0;
      m_tag  = '0;
      m_data = '0;
      m_src  = '0;
      m_busy = '0;
      m_conf = '0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // Monitor: compare the registered broadcast after each rising edge.
   always @(posedge CLK) begin
      #2;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("cdb_valid", {63'd0, bus.CDB_VALID}, {63'd0, mon_e.valid});
         check("cdb_tag",   {60'd0, bus.CDB_TAG},   {60'd0, mon_e.tag});
         check("cdb_data",  {32'd0, bus.CDB_DATA},  {32'd0, mon_e.data});
         check("cdb_src",   {62'd0, bus.CDB_SRC},   {62'd0, mon_e.src});
      end
   end

   initial begin
      int g;
      bus.REQ_VALID = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         cur_tag[i]  = 4'(i + 1);
         cur_data[i] = 32'h1000 + 32'(i);
         pend[i]     = 1'b0;
      end
      bus.REQ_TAG0 = 4'd1; bus.REQ_TAG1 = 4'd2; bus.REQ_TAG2 = 4'd3; bus.REQ_TAG3 = 4'd4;
      bus.REQ_DATA0 = '0; bus.REQ_DATA1 = '0; bus.REQ_DATA2 = '0; bus.REQ_DATA3 = '0;
      @(negedge CLK);
      do_reset();

      // single requester 2 with tag 5
      cur_tag[2]  = 4'd5;
      cur_data[2] = 32'hDEADBEEF;
      cycle(4'b0100, 1'b0, g);
      // all four eligible from reset: rotation 0,1,2,3,...
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1111, 1'b0, g);
         check("rr_order", 64'(g), 64'(i % 4));
      end
      // asynchronous reset while a broadcast is on the bus
      do_reset();
      // valid request with invalid tag is ignored
      cur_tag[0] = 4'd0;
      cycle(4'b0001, 1'b0, g);
      cur_tag[0] = 4'd7;
      // move the pointer, flush, then expect restart from index 0
      cycle(4'b0100, 1'b0, g);
      cycle(4'b0011, 1'b1, g);
      cycle(4'b0011, 1'b0, g);
      check("post_flush", 64'(g), 64'd0);
      cycle(4'b0000, 1'b0, g);

`ifdef CDB_ARB_PERF_EN
      do_reset();
      for (int i = 0; i < 10; i++) cycle(4'b0011, 1'b0, g);
      check("busy10", {32'd0, busy_cnt}, 64'd10);
      check("conf10", {32'd0, conf_cnt}, 64'd10);
`endif

      // randomized traffic; requests hold until granted
      for (int c = 0; c < 400; c++) begin
         logic [3:0] v;
         logic       fl;
         if (c == 200) do_reset();
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] || cur_tag[i] == 4'd0) begin
               pend[i]     = ($urandom_range(0, 2) != 0);
               cur_tag[i]  = 4'($urandom_range(0, 15));
               cur_data[i] = $urandom;
            end
            v[i] = pend[i];
         end
         fl = ($urandom_range(0, 9) == 0);
         cycle(v, fl, g);
         if (g >= 0) pend[g] = 1'b0;
      end

`ifdef CDB_ARB_PERF_EN
      check("busy_cnt", {32'd0, busy_cnt}, {32'd0, m_busy});
      check("conf_cnt", {32'd0, conf_cnt}, {32'd0, m_conf});
`endif

      @(posedge CLK);
      #3;
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter TAG_W, default 4: width of the reservation-station tag; tag value 0 is INVALID.
REQ-002 Parameter DATA_W, default 32: width of broadcast result data.
REQ-003 One clock; reset is asynchronous and active-low; ports named CLK and RST_N.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 FLUSH  input  1  synchronous squash of pending/outgoing broadcast.
REQ-007 REQ_VALID  input  4  per-unit request; bit0 LOAD_1, bit1 LOAD_2, bit2 ALU_1, bit3 ALU_2.
REQ-008 REQ_TAG0..REQ_TAG3  input  TAG_W each  tag of requester i.
REQ-009 REQ_DATA0..REQ_DATA3  input  DATA_W each  result of requester i.
REQ-010 GNT  output  4  combinational one-hot grant, same cycle as request.
REQ-011 CDB_VALID  output  1  registered broadcast valid.
REQ-012 CDB_TAG  output  TAG_W  registered broadcast tag.
REQ-013 CDB_DATA  output  DATA_W  registered broadcast data.
REQ-014 CDB_SRC  output  2  registered index of the granted requester.

Function
REQ-015 Requester i SHALL be eligible only when REQ_VALID[i]=1 and REQ_TAGi != 0.
REQ-016 GNT SHALL be at most one-hot, zero when FLUSH=1, RST_N=0, or no requester is eligible.
REQ-017 Arbitration SHALL be round-robin: search eligible requesters starting at PTR (2-bit) ascending mod 4; first hit is granted.
REQ-018 On a grant to index k, PTR SHALL become (k+1) mod 4 at the next edge; with no grant PTR SHALL hold.
REQ-019 On a grant to k at edge t, CDB_VALID=1, CDB_TAG=REQ_TAGk, CDB_DATA=REQ_DATAk, CDB_SRC=k SHALL appear after edge t (1-cycle latency) for exactly one cycle unless granted again.
REQ-020 With no grant, CDB_VALID SHALL be 0 next cycle; CDB_TAG, CDB_DATA, CDB_SRC SHALL hold last values.
REQ-021 Requesters SHALL hold REQ_VALID/TAG/DATA stable until GNT[i]=1 is sampled; a request is consumed on the edge where GNT[i]=1.
REQ-022 The block SHALL sustain one broadcast per cycle; with all four eligible continuously, grants SHALL rotate 0,1,2,3,0... from PTR.
REQ-023 FLUSH=1 SHALL force CDB_VALID=0 and PTR=0 at the next edge, and no request is consumed that cycle.
REQ-024 A broadcast already on CDB when FLUSH asserts SHALL remain for its single cycle; only the next broadcast is suppressed.

Reset
REQ-025 RST_N=0 SHALL immediately clear CDB_VALID, CDB_TAG, CDB_DATA, CDB_SRC, PTR (and counters if built) to 0, including mid-broadcast.
REQ-026 First grant after RST_N deasserts SHALL search from index 0.

Configuration
REQ-027 Macro CDB_ARB_PERF_EN defined: outputs CDB_BUSY_CNT (32) and CDB_CONFLICT_CNT (32) SHALL exist.
REQ-028 CDB_BUSY_CNT SHALL increment each cycle a grant occurs; CDB_CONFLICT_CNT each cycle with >=2 eligible requesters; both wrap 0xFFFFFFFF->0, cleared by reset, not by FLUSH.
REQ-029 Macro undefined: the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Post-reset, REQ_VALID=4'b0100, TAG2=5, DATA2=0xDEADBEEF -> GNT=4'b0100 same cycle; next cycle CDB_VALID=1, TAG=5, DATA=0xDEADBEEF, SRC=2; PTR=3.
REQ-031 REQ_VALID=4'b1111 held, all tags nonzero, 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; CDB_VALID=1 every cycle after the first.
REQ-032 REQ_VALID=4'b0001 with REQ_TAG0=0 -> GNT=0, CDB_VALID=0 next cycle.
REQ-033 REQ_VALID=4'b0011 with FLUSH=1 for one cycle -> GNT=0, CDB_VALID=0 next cycle, next grant goes to index 0.
REQ-034 RST_N pulled low asynchronously while CDB_VALID=1 -> CDB_VALID, TAG, DATA, SRC=0 before next edge.
REQ-035 With CDB_ARB_PERF_EN, 10 cycles REQ_VALID=4'b0011 -> CDB_BUSY_CNT=10, CDB_CONFLICT_CNT=10.
